phasediff_array: RTL and testbench

//  Multi-channel successor of the two-input phase differencer for the USBL array.

---
 rtl/phasediff_array.sv | 117 +++++++++++
 tb/tb_phasediff_array.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phasediff_array.sv
// Multi-channel phase differencer: wraps ch[k]-ch[0] to [-180,+180] deg (9Q10),
// optionally averages over 2**AVG_LOG2 frames, one shared subtractor stepped per baseline.
module phasediff_array #(
  parameter int NCH      = 3,
  parameter int W_INT    = 9,
  parameter int W_FRAC   = 10,
  parameter int AVG_LOG2 = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NCH*(W_INT+W_FRAC)-1:0]       in_phase,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [(NCH-1)*(W_INT+W_FRAC)-1:0]   out_diff
);

  localparam int W  = W_INT + W_FRAC;
  localparam int AW = W + AVG_LOG2;
  localparam int KW = (NCH > 2) ? $clog2(NCH) : 1;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic signed [W:0] HALF = (W+1)'(180 << W_FRAC);
  localparam logic signed [W:0] FULL = (W+1)'(360 << W_FRAC);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                   state_reg, state_next;
  logic signed [W-1:0]      in_ph [NCH];
  logic signed [W-1:0]      ph_reg [NCH];
  logic signed [AW-1:0]     acc_reg [NCH];
  logic [KW-1:0]            k_reg;
  logic [CW-1:0]            frame_cnt_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;
  logic [(NCH-1)*W-1:0]     out_diff_reg;
  logic signed [W:0]        d_raw, d_wrap;
  logic                     last_k, frame_done;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign in_ph[gi] = in_phase[gi*W +: W];
  end

  assign last_k     = (k_reg == KW'(NCH - 1));
  assign frame_done = (frame_cnt_reg == CW'((1 << AVG_LOG2) - 1));

  // The shared subtractor: one extra bit so the raw difference never overflows,
  // and a single +/-360 correction is enough for any pair of W-bit inputs.
  always_comb begin
    d_raw = (W+1)'(ph_reg[k_reg]) - (W+1)'(ph_reg[0]);
    if (d_raw > HALF)
      d_wrap = d_raw - FULL;
    else if (d_raw < -HALF)
      d_wrap = d_raw + FULL;
    else
      d_wrap = d_raw;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid && in_ready_reg) state_next = CALC;
      CALC:    if (last_k) state_next = frame_done ? OUT : IDLE;
      OUT:     if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_diff_reg  <= '0;
      frame_cnt_reg <= '0;
      k_reg         <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_reg[i] <= '0;
        ph_reg[i]  <= '0;
      end
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            for (int i = 0; i < NCH; i++) ph_reg[i] <= in_ph[i];
            k_reg <= KW'(1);
          end
        end
        CALC: begin
          acc_reg[k_reg] <= acc_reg[k_reg] + AW'(d_wrap);
          k_reg          <= k_reg + KW'(1);
          if (last_k) frame_cnt_reg <= frame_cnt_reg + CW'(1);
        end
        OUT: begin
          // First OUT cycle latches the mean; it then stays frozen until taken.
          if (!out_valid_reg) begin
            for (int i = 1; i < NCH; i++)
              out_diff_reg[(i-1)*W +: W] <= W'(acc_reg[i] >>> AVG_LOG2);
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            frame_cnt_reg <= '0;
            for (int i = 0; i < NCH; i++) acc_reg[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_diff  = out_diff_reg;

endmodule

// File: tb/tb_phasediff_array.sv
// Bench for phasediff_array: directed wrap/average/backpressure/reset steps on
// NCH=3 instances, then a randomized NCH=4 run against a degree-level model.
module tb_phasediff_array;
  localparam int W   = 19;
  localparam int ONE = 1024;
  localparam int NF  = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic a_valid, a_ready, a_ovalid, a_oready;
  logic [3*W-1:0] a_phase;
  logic [2*W-1:0] a_diff;
  logic b_valid, b_ready, b_ovalid, b_oready;
  logic [3*W-1:0] b_phase;
  logic [2*W-1:0] b_diff;
  logic c_valid, c_ready, c_ovalid, c_oready;
  logic [4*W-1:0] c_phase;
  logic [3*W-1:0] c_diff;

  int checks = 0;
  int errors = 0;

  phasediff_array #(.NCH(3), .W_INT(9), .W_FRAC(10), .AVG_LOG2(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready), .in_phase(a_phase),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_diff(a_diff));
  phasediff_array #(.NCH(3), .W_INT(9), .W_FRAC(10), .AVG_LOG2(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready), .in_phase(b_phase),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_diff(b_diff));
  phasediff_array #(.NCH(4), .W_INT(9), .W_FRAC(10), .AVG_LOG2(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_valid), .in_ready(c_ready), .in_phase(c_phase),
    .out_valid(c_ovalid), .out_ready(c_oready), .out_diff(c_diff));

  task automatic check(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic integer sx(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = v;
    return s;
  endfunction

  function automatic int deg(input int d);
    return d * ONE;
  endfunction

  // Reference wrap: bring any difference into [-180,+180], endpoints kept.
  function automatic int wrapd(input int d);
    int r;
    r = d;
    while (r > 180 * ONE) r -= 360 * ONE;
    while (r < -180 * ONE) r += 360 * ONE;
    return r;
  endfunction

  function automatic int floor_div2(input int s);
    return (s - (((s % 2) + 2) % 2)) / 2;
  endfunction

  task automatic send_a(input int p0, input int p1, input int p2);
    int n = 0;
    a_phase = {W'(p2), W'(p1), W'(p0)};
    a_valid = 1'b1;
    while (a_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("a_accept_wait", (n < 50) ? 1 : 0, 1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input int p0, input int p1, input int p2);
    int n = 0;
    b_phase = {W'(p2), W'(p1), W'(p0)};
    b_valid = 1'b1;
    while (b_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("b_accept_wait", (n < 50) ? 1 : 0, 1);
    tick();
    b_valid = 1'b0;
  endtask

  task automatic send_c(input int p[4]);
    int n = 0;
    for (int i = 0; i < 4; i++) c_phase[i*W +: W] = W'(p[i]);
    c_valid = 1'b1;
    while (c_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("c_accept_wait", (n < 50) ? 1 : 0, 1);
    tick();
    c_valid = 1'b0;
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (a_ovalid !== 1'b1 && lat < 50) begin tick(); lat++; end
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (b_ovalid !== 1'b1 && lat < 50) begin tick(); lat++; end
  endtask

  task automatic take_a();
    a_oready = 1'b1;
    tick();
    a_oready = 1'b0;
    check("a_ovalid_after_take", a_ovalid, 0);
    check("a_ready_after_take", a_ready, 1);
  endtask

  task automatic take_b();
    b_oready = 1'b1;
    tick();
    b_oready = 1'b0;
    check("b_ovalid_after_take", b_ovalid, 0);
  endtask

  initial begin
    int lat;
    int p[4];
    int sum[3];
    reset = 1'b0;
    a_valid = 0; a_oready = 0; a_phase = '0;
    b_valid = 0; b_oready = 0; b_phase = '0;
    c_valid = 0; c_oready = 0; c_phase = '0;
    repeat (3) tick();

    // Reset state
    check("rst_a_ready", a_ready, 0);
    check("rst_a_ovalid", a_ovalid, 0);
    check("rst_a_diff1", sx(a_diff[0 +: W]), 0);
    check("rst_a_diff2", sx(a_diff[W +: W]), 0);
    check("rst_c_ready", c_ready, 0);
    reset = 1'b1;
    check("rel_a_ready_same", a_ready, 0);
    tick();
    check("rel_a_ready_next", a_ready, 1);
    $display("reset released, in_ready high");

    // T1: wrap and latency
    send_a(deg(10), deg(200), deg(-170));
    check("t1_ready_in_calc", a_ready, 0);
    wait_a(lat);
    check("t1_latency", lat, 3);
    check("t1_b1", sx(a_diff[0 +: W]), deg(-170));
    check("t1_b2", sx(a_diff[W +: W]), deg(-180));
    take_a();
    $display("T1 frame: b1=%0d b2=%0d lat=%0d", sx(a_diff[0 +: W]), sx(a_diff[W +: W]), lat);

    // T2: exact +/-180 bounds
    send_a(deg(-90), deg(90), deg(-90));
    wait_a(lat);
    check("t2a_b1", sx(a_diff[0 +: W]), deg(180));
    check("t2a_b2", sx(a_diff[W +: W]), 0);
    take_a();
    $display("T2a frame: b1=%0d b2=%0d", sx(a_diff[0 +: W]), sx(a_diff[W +: W]));
    send_a(deg(90), deg(-90), deg(90));
    wait_a(lat);
    check("t2b_b1", sx(a_diff[0 +: W]), deg(-180));
    check("t2b_b2", sx(a_diff[W +: W]), 0);
    take_a();
    $display("T2b frame: b1=%0d b2=%0d", sx(a_diff[0 +: W]), sx(a_diff[W +: W]));

    // T4: backpressure; a frame offered meanwhile must be held, not lost
    send_a(0, deg(45), deg(-30));
    wait_a(lat);
    a_phase = {W'(deg(5)), W'(deg(-100)), W'(deg(100))};
    a_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("t4_ovalid_hold", a_ovalid, 1);
      check("t4_b1_hold", sx(a_diff[0 +: W]), deg(45));
      check("t4_b2_hold", sx(a_diff[W +: W]), deg(-30));
      check("t4_ready_low", a_ready, 0);
      tick();
    end
    take_a();
    $display("T4 frame: held 20 cycles, b1=%0d b2=%0d", sx(a_diff[0 +: W]), sx(a_diff[W +: W]));
    tick();
    a_valid = 1'b0;
    wait_a(lat);
    check("t4_held_lat", lat, 3);
    check("t4_held_b1", sx(a_diff[0 +: W]), deg(160));
    check("t4_held_b2", sx(a_diff[W +: W]), deg(-95));
    take_a();
    $display("T4 held frame: b1=%0d b2=%0d", sx(a_diff[0 +: W]), sx(a_diff[W +: W]));

    // T3: average of four frames, with a floor-rounded -1 raw on b2
    send_b(0, deg(10), -1);
    for (int f = 1; f < 4; f++) begin
      repeat (3) begin tick(); check("t3_no_early_out", b_ovalid, 0); end
      send_b(0, deg(10 * f + ((f == 3) ? 11 : 10)), 0);
    end
    wait_b(lat);
    check("t3_latency", lat, 3);
    check("t3_b1", sx(b_diff[0 +: W]), 25856);
    check("t3_b2", sx(b_diff[W +: W]), -1);
    take_b();
    $display("T3 avg: b1=%0d b2=%0d", sx(b_diff[0 +: W]), sx(b_diff[W +: W]));

    // T5: reset pulse in CALC of frame 3 discards the partial sum
    send_b(0, deg(170), deg(170));
    send_b(0, deg(170), deg(170));
    send_b(0, deg(170), deg(170));
    reset = 1'b0;
    tick();
    check("t5_ready", b_ready, 0);
    check("t5_ovalid", b_ovalid, 0);
    check("t5_b1_clr", sx(b_diff[0 +: W]), 0);
    check("t5_b2_clr", sx(b_diff[W +: W]), 0);
    reset = 1'b1;
    tick();
    send_b(deg(100), deg(140), deg(-79));
    send_b(deg(100), deg(40), deg(-79));
    send_b(deg(100), deg(200), deg(-79));
    send_b(deg(100), deg(111), deg(-79));
    wait_b(lat);
    check("t5_wait", (lat < 50) ? 1 : 0, 1);
    check("t5_b1", sx(b_diff[0 +: W]), 23296);
    check("t5_b2", sx(b_diff[W +: W]), deg(-179));
    take_b();
    $display("T5 avg after reset: b1=%0d b2=%0d", sx(b_diff[0 +: W]), sx(b_diff[W +: W]));

    // T6: random regression, NCH=4 with pairwise averaging
    for (int f = 0; f < NF; f += 2) begin
      for (int k = 0; k < 3; k++) sum[k] = 0;
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(3) == 0)
            p[i] = (int'($urandom_range(4)) * 90 - 180) * ONE;
          else
            p[i] = int'($urandom_range(2 * 262144 - 1)) - 262144;
        end
        for (int k = 0; k < 3; k++) sum[k] += wrapd(p[k + 1] - p[0]);
        send_c(p);
      end
      lat = 0;
      while (c_ovalid !== 1'b1 && lat < 50) begin tick(); lat++; end
      check("t6_wait", (lat < 50) ? 1 : 0, 1);
      for (int k = 0; k < 3; k++)
        check($sformatf("t6_b%0d_pair%0d", k + 1, f / 2), sx(c_diff[k*W +: W]), floor_div2(sum[k]));
      $display("T6 pair %0d: b1=%0d b2=%0d b3=%0d", f / 2,
               sx(c_diff[0 +: W]), sx(c_diff[W +: W]), sx(c_diff[2*W +: W]));
      repeat ($urandom_range(2)) tick();
      c_oready = 1'b1;
      tick();
      c_oready = 1'b0;
      check("t6_ovalid_drop", c_ovalid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
